// File: rtl/read_route_tracker.sv
// Read-path route tracker: counts outstanding AR bursts for one master and locks the
// R-channel demux/mux select to a single slave until every burst has returned RLAST.
module read_route_tracker #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic [1:0]       ar_sel,
  input  logic             s_arvalid,
  input  logic             s_arready,
  output logic             m_arready,
  input  logic             r_valid,
  input  logic             r_last,
  input  logic             s_rready,
  output logic             m_rready,
  output logic [1:0]       rd_sel,
  output logic             rd_sel_valid,
  output logic [CNT_W-1:0] outstanding,
  output logic             err_unexpected_r
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       locked_sel_reg, locked_sel_next;
  logic             err_reg, err_next;

  logic ar_ok;
  logic ar_fire;
  logic r_end;

  // ar_ok looks only at registered state, so a same-cycle RLAST never opens a full slot.
  always_comb begin
    ar_ok = 1'b1;
    if (state_reg == ACTIVE) begin
      ar_ok = (ar_sel == locked_sel_reg) && (cnt_reg < MAX_CNT);
    end
  end

  assign m_arready = s_arready & ar_ok & ARESETN;
  assign m_rready  = s_rready & (state_reg == ACTIVE);
  assign ar_fire   = s_arvalid & m_arready;
  assign r_end     = r_valid & m_rready & r_last & (state_reg == ACTIVE);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    locked_sel_next = locked_sel_reg;
    err_next        = err_reg;
    case (state_reg)
      IDLE: begin
        if (r_valid) begin
          err_next = 1'b1;
        end
        if (ar_fire) begin
          locked_sel_next = ar_sel;
          cnt_next        = ONE_CNT;
          state_next      = ACTIVE;
        end
      end
      ACTIVE: begin
        case ({ar_fire, r_end})
          2'b10: cnt_next = cnt_reg + ONE_CNT;
          2'b01: begin
            cnt_next = cnt_reg - ONE_CNT;
            if (cnt_reg == ONE_CNT) begin
              state_next = IDLE;
            end
          end
          default: cnt_next = cnt_reg;
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      locked_sel_reg <= 2'd0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      locked_sel_reg <= locked_sel_next;
      err_reg        <= err_next;
    end
  end

  assign rd_sel           = locked_sel_reg;
  assign rd_sel_valid     = (state_reg == ACTIVE);
  assign outstanding      = cnt_reg;
  assign err_unexpected_r = err_reg;

endmodule

// File: tb/tb_read_route_tracker.sv
// Directed bench for read_route_tracker: hand-computed expectations checked with
// immediate assertions after each stimulus step.
module tb_read_route_tracker;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic [1:0] ar_sel;
  logic       s_arvalid, s_arready;
  logic       m_arready;
  logic       r_valid, r_last, s_rready;
  logic       m_rready;
  logic [1:0] rd_sel;
  logic       rd_sel_valid;
  logic [3:0] outstanding;
  logic       err_unexpected_r;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  read_route_tracker #(.MAX_OUTSTANDING(4), .CNT_W(4)) dut (
    .ACLK             (ACLK),
    .ARESETN          (ARESETN),
    .ar_sel           (ar_sel),
    .s_arvalid        (s_arvalid),
    .s_arready        (s_arready),
    .m_arready        (m_arready),
    .r_valid          (r_valid),
    .r_last           (r_last),
    .s_rready         (s_rready),
    .m_rready         (m_rready),
    .rd_sel           (rd_sel),
    .rd_sel_valid     (rd_sel_valid),
    .outstanding      (outstanding),
    .err_unexpected_r (err_unexpected_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new stimulus is applied.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESETN = 1'b0; ar_sel = 2'd0; s_arvalid = 1'b0; s_arready = 1'b1;
    r_valid = 1'b0; r_last = 1'b0; s_rready = 1'b1;
    #12;
    chk("rst m_arready",    m_arready, 0);
    chk("rst m_rready",     m_rready, 0);
    chk("rst rd_sel",       rd_sel, 0);
    chk("rst rd_sel_valid", rd_sel_valid, 0);
    chk("rst outstanding",  outstanding, 0);
    chk("rst err",          err_unexpected_r, 0);
    @(negedge ACLK); ARESETN = 1'b1;
    step();
    chk("idle m_rready",     m_rready, 0);
    chk("idle rd_sel_valid", rd_sel_valid, 0);
    chk("idle m_arready",    m_arready, 1);

    // Single AR to slave 2, three-beat burst.
    ar_sel = 2'd2; s_arvalid = 1'b1; #1;
    chk("ar2 m_arready", m_arready, 1);
    step();
    s_arvalid = 1'b0;
    chk("ar2 outstanding", outstanding, 1);
    chk("ar2 rd_sel", rd_sel, 2);
    chk("ar2 rd_sel_valid", rd_sel_valid, 1);
    r_valid = 1'b1; r_last = 1'b0; #1;
    chk("beat1 m_rready", m_rready, 1);
    step();
    chk("beat2 m_rready", m_rready, 1);
    chk("beat2 outstanding", outstanding, 1);
    step();
    r_last = 1'b1; #1;
    chk("beat3 m_rready", m_rready, 1);
    step();
    r_valid = 1'b0; r_last = 1'b0; #1;
    chk("burst end outstanding", outstanding, 0);
    chk("burst end valid", rd_sel_valid, 0);
    chk("burst end m_rready", m_rready, 0);
    chk("burst end err", err_unexpected_r, 0);

    // Fill to MAX_OUTSTANDING on slave 1, then probe the full boundary.
    ar_sel = 2'd1; s_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("full outstanding", outstanding, 4);
    chk("full m_arready", m_arready, 0);
    r_valid = 1'b1; r_last = 1'b1; #1;
    chk("full+r_end m_arready", m_arready, 0);
    step();
    r_valid = 1'b0; r_last = 1'b0; #1;
    chk("after r_end outstanding", outstanding, 3);
    chk("after r_end m_arready", m_arready, 1);
    step();
    s_arvalid = 1'b0;
    chk("5th AR outstanding", outstanding, 4);
    chk("5th AR rd_sel", rd_sel, 1);
    r_valid = 1'b1; r_last = 1'b1;
    for (int i = 0; i < 4; i++) step();
    r_valid = 1'b0; r_last = 1'b0; #1;
    chk("drain outstanding", outstanding, 0);
    chk("drain valid", rd_sel_valid, 0);

    // Locked to slave 0; AR to slave 3 stalls until the tracker is idle.
    ar_sel = 2'd0; s_arvalid = 1'b1;
    step();
    ar_sel = 2'd3; #1;
    chk("other slave m_arready", m_arready, 0);
    step();
    chk("other slave held", m_arready, 0);
    chk("slave0 outstanding", outstanding, 1);
    r_valid = 1'b1; r_last = 1'b1; #1;
    chk("other slave at r_end", m_arready, 0);
    step();
    r_valid = 1'b0; r_last = 1'b0; #1;
    chk("idle gap outstanding", outstanding, 0);
    chk("idle gap m_arready", m_arready, 1);
    step();
    s_arvalid = 1'b0;
    chk("slave3 rd_sel", rd_sel, 3);
    chk("slave3 outstanding", outstanding, 1);

    // Simultaneous AR and RLAST at outstanding==1.
    ar_sel = 2'd3; s_arvalid = 1'b1; r_valid = 1'b1; r_last = 1'b1; #1;
    chk("simul m_arready", m_arready, 1);
    chk("simul m_rready", m_rready, 1);
    step();
    s_arvalid = 1'b0; r_valid = 1'b0; r_last = 1'b0; #1;
    chk("simul outstanding", outstanding, 1);
    chk("simul valid", rd_sel_valid, 1);
    chk("simul rd_sel", rd_sel, 3);
    r_valid = 1'b1; r_last = 1'b1;
    step();
    r_valid = 1'b0; r_last = 1'b0; #1;
    chk("simul drain", outstanding, 0);

    // Unexpected R beat while idle.
    r_valid = 1'b1; #1;
    chk("unexp m_rready", m_rready, 0);
    step();
    r_valid = 1'b0; #1;
    chk("unexp err set", err_unexpected_r, 1);
    chk("unexp outstanding", outstanding, 0);
    step();
    chk("unexp err sticky", err_unexpected_r, 1);

    // Reset mid-burst at outstanding==3.
    ar_sel = 2'd2; s_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    s_arvalid = 1'b0; #1;
    chk("pre-reset outstanding", outstanding, 3);
    #2; ARESETN = 1'b0; #1;
    chk("mid reset outstanding", outstanding, 0);
    chk("mid reset valid", rd_sel_valid, 0);
    chk("mid reset err", err_unexpected_r, 0);
    @(negedge ACLK); ARESETN = 1'b1;
    step();
    r_valid = 1'b1;
    step();
    r_valid = 1'b0; #1;
    chk("post-reset stray R", err_unexpected_r, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
